// File: rtl/ace_pkg.sv
// ace_pkg: shared front-end widths and types for the fetch/decode boundary.
//   ACE_FETCH_W  - instructions delivered by fetch per cycle
//   ACE_DECODE_W - instructions consumed by decode per cycle
//   ACE_INST_W   - instruction word width
//   ACE_PC_W     - program counter width
package ace_pkg;

  localparam int unsigned ACE_FETCH_W  = 8;
  localparam int unsigned ACE_DECODE_W = 4;
  localparam int unsigned ACE_INST_W   = 32;
  localparam int unsigned ACE_PC_W     = 64;

  typedef logic [ACE_INST_W-1:0] ace_inst_t;
  typedef logic [ACE_PC_W-1:0]   ace_pc_t;

endpackage

// File: rtl/ace_thermo_cnt.sv
// ace_thermo_cnt: converts an N-bit thermometer vector (ones from bit 0) to a
// count. Counting stops at the first zero, so any set bits above it are ignored.
//   vec_i - thermometer input vector
//   cnt_o - number of leading ones starting at bit 0
module ace_thermo_cnt #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]             vec_i,
  output logic [$clog2(N+1)-1:0]   cnt_o
);

  always_comb begin
    logic run;
    run   = 1'b1;
    cnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      run = run & vec_i[i];
      if (run) cnt_o = cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/ace_instbuf.sv
// ace_instbuf: circular instruction queue between fetch and decode.
// Accepts up to FW instructions per cycle (all-or-nothing, only when not full)
// and presents the oldest DW entries in program order. Outputs depend on
// registered state only.
// Optional feature: define ACE_INSTBUF_PC_EN to store per-entry PCs and drive
// out_pc_o; otherwise out_pc_o is tied to 0 and fetch_pc_i is unused.
//   clock          - rising-edge clock
//   reset          - synchronous active-high reset
//   retire_flush_i - discard all entries
//   fetch_vld_i    - per-slot valid, thermometer from slot 0
//   fetch_inst_i   - fetched instructions, slot k at [32k+31:32k]
//   fetch_pc_i     - PC of fetch slot 0 (slot k = +4k)
//   deq_cnt_i      - head entries consumed this cycle (clamped to valid count)
//   out_vld_o      - per-output-slot valid, thermometer
//   out_inst_o     - oldest DW entries, slot 0 oldest
//   out_pc_o       - PCs of the output slots
//   full_o         - fewer than FW free entries
//   empty_o        - no entries held
module ace_instbuf
  import ace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned FW    = ACE_FETCH_W,
  parameter int unsigned DW    = ACE_DECODE_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     retire_flush_i,
  input  logic [FW-1:0]            fetch_vld_i,
  input  logic [ACE_INST_W*FW-1:0] fetch_inst_i,
  input  logic [ACE_PC_W-1:0]      fetch_pc_i,
  input  logic [2:0]               deq_cnt_i,
  output logic [DW-1:0]            out_vld_o,
  output logic [ACE_INST_W*DW-1:0] out_inst_o,
  output logic [ACE_PC_W*DW-1:0]   out_pc_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned PNW = $clog2(FW + 1);
  localparam int unsigned VNW = $clog2(DW + 1);

  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic [PNW-1:0] pn;
  logic [VNW-1:0] vcnt;
  logic [2:0]     pe;
  logic           push_acc;

  logic [FW-1:0]  we;
  logic [AW-1:0]  widx [FW];

  // Entry storage is intentionally not reset.
  ace_inst_t      inst_q  [DEPTH];
  logic           ent_we  [DEPTH];
  ace_inst_t      ent_wd  [DEPTH];

  ace_thermo_cnt #(.N(FW)) u_push_cnt (
    .vec_i (fetch_vld_i),
    .cnt_o (pn)
  );

  ace_thermo_cnt #(.N(DW)) u_vld_cnt (
    .vec_i (out_vld_o),
    .cnt_o (vcnt)
  );

  assign full_o  = count_q > CW'(DEPTH - FW);
  assign empty_o = count_q == '0;

  // Writes are suppressed during flush/reset so no stale push lands in storage.
  assign push_acc = !full_o && !retire_flush_i && !reset;

  always_comb begin
    for (int unsigned j = 0; j < DW; j++) begin
      out_vld_o[j] = count_q > CW'(j);
    end
  end

  always_comb begin
    pe      = (deq_cnt_i < 3'(vcnt)) ? deq_cnt_i : 3'(vcnt);
    head_d  = head_q + AW'(pe);
    tail_d  = tail_q;
    count_d = count_q - CW'(pe);
    if (push_acc) begin
      tail_d  = tail_q + AW'(pn);
      count_d = count_d + CW'(pn);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || retire_flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < FW; k++) begin
      we[k]   = push_acc && (PNW'(k) < pn);
      widx[k] = tail_q + AW'(k);
    end
  end

  // Per-entry decode of the FW write ports; at most one slot targets an entry.
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      ent_we[e] = 1'b0;
      ent_wd[e] = '0;
      for (int unsigned k = 0; k < FW; k++) begin
        if (we[k] && (widx[k] == AW'(e))) begin
          ent_we[e] = 1'b1;
          ent_wd[e] = fetch_inst_i[ACE_INST_W*k +: ACE_INST_W];
        end
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_inst_ent
    always_ff @(posedge clock) begin
      if (ent_we[e]) inst_q[e] <= ent_wd[e];
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < DW; j++) begin
      out_inst_o[ACE_INST_W*j +: ACE_INST_W] =
        out_vld_o[j] ? inst_q[head_q + AW'(j)] : '0;
    end
  end

`ifdef ACE_INSTBUF_PC_EN
  ace_pc_t pc_q   [DEPTH];
  ace_pc_t pc_wd  [DEPTH];

  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      pc_wd[e] = '0;
      for (int unsigned k = 0; k < FW; k++) begin
        if (we[k] && (widx[k] == AW'(e))) begin
          pc_wd[e] = fetch_pc_i + ACE_PC_W'(4 * k);
        end
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_pc_ent
    always_ff @(posedge clock) begin
      if (ent_we[e]) pc_q[e] <= pc_wd[e];
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < DW; j++) begin
      out_pc_o[ACE_PC_W*j +: ACE_PC_W] =
        out_vld_o[j] ? pc_q[head_q + AW'(j)] : '0;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^fetch_pc_i;
  assign out_pc_o  = '0;
`endif

endmodule

// File: tb/tb_ace_instbuf.sv
module tb_ace_instbuf;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned FW    = 8;
  localparam int unsigned DW    = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         retire_flush_i;
  logic [7:0]   fetch_vld_i;
  logic [255:0] fetch_inst_i;
  logic [63:0]  fetch_pc_i;
  logic [2:0]   deq_cnt_i;
  logic [3:0]   out_vld_o;
  logic [127:0] out_inst_o;
  logic [255:0] out_pc_o;
  logic         full_o;
  logic         empty_o;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clock = ~clock;

  ace_instbuf #(.DEPTH(DEPTH), .FW(FW), .DW(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .retire_flush_i (retire_flush_i),
    .fetch_vld_i    (fetch_vld_i),
    .fetch_inst_i   (fetch_inst_i),
    .fetch_pc_i     (fetch_pc_i),
    .deq_cnt_i      (deq_cnt_i),
    .out_vld_o      (out_vld_o),
    .out_inst_o     (out_inst_o),
    .out_pc_o       (out_pc_o),
    .full_o         (full_o),
    .empty_o        (empty_o)
  );

  // Reference model: a plain FIFO of {inst, pc} in program order.
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic        rst;
    logic        flush;
    logic [7:0]  vld;
    logic [31:0] ib;
    logic [63:0] pc;
    logic [2:0]  deq;
    logic [3:0]  evld;
    logic [31:0] einst0;
    logic        efull;
    logic        eempty;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(input logic r, input logic f, input logic [7:0] v,
                              input logic [31:0] ib, input logic [63:0] pc,
                              input logic [2:0] d, input logic [3:0] ev,
                              input logic [31:0] ei, input logic ef, input logic ee);
    vec_t t;
    t.rst = r; t.flush = f; t.vld = v; t.ib = ib; t.pc = pc; t.deq = d;
    t.evld = ev; t.einst0 = ei; t.efull = ef; t.eempty = ee;
    return t;
  endfunction

  function automatic logic [255:0] seq_insts(input logic [31:0] base);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = base + 32'(k);
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic [7:0] v,
                            input logic [255:0] insts, input logic [63:0] pc,
                            input logic [2:0] d);
    int unsigned pn, vis, pe;
    bit stop, full;
    pn = 0; stop = 0;
    for (int k = 0; k < 8; k++) begin
      if (!stop && v[k]) pn++;
      else stop = 1;
    end
    full = mq.size() > (DEPTH - FW);
    if (r || f) begin
      mq.delete();
    end else begin
      vis = (mq.size() < DW) ? mq.size() : DW;
      pe  = (d < vis) ? d : vis;
      for (int unsigned i = 0; i < pe; i++) void'(mq.pop_front());
      if (!full) begin
        for (int unsigned k = 0; k < pn; k++) begin
          ent_t e;
          e.inst = insts[32*k +: 32];
          e.pc   = pc + 64'(4 * k);
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic model_check();
    logic [255:0] ev, ei, ep;
    ev = '0; ei = '0; ep = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < mq.size()) begin
        ev[j] = 1'b1;
        ei[32*j +: 32] = mq[j].inst;
`ifdef ACE_INSTBUF_PC_EN
        ep[64*j +: 64] = mq[j].pc;
`endif
      end
    end
    chk("m_vld",   {252'd0, out_vld_o}, ev);
    chk("m_inst",  {128'd0, out_inst_o}, ei);
    chk("m_pc",    out_pc_o, ep);
    chk("m_full",  {255'd0, full_o},  {255'd0, mq.size() > (DEPTH - FW)});
    chk("m_empty", {255'd0, empty_o}, {255'd0, mq.size() == 0});
  endtask

  task automatic apply(input logic r, input logic f, input logic [7:0] v,
                       input logic [255:0] insts, input logic [63:0] pc,
                       input logic [2:0] d);
    reset = r; retire_flush_i = f; fetch_vld_i = v;
    fetch_inst_i = insts; fetch_pc_i = pc; deq_cnt_i = d;
    @(posedge clock);
    model_step(r, f, v, insts, pc, d);
    #1;
  endtask

  initial begin
    logic [255:0] ri;
    logic [7:0]   rv;
    logic [63:0]  rp;
    int unsigned  len;

    tbl[0]  = mk(1, 0, 8'h00, 32'h000, 64'h0,    0, 4'h0, 32'h000, 0, 1);
    tbl[1]  = mk(0, 0, 8'hFF, 32'h100, 64'h1000, 0, 4'hF, 32'h100, 0, 0);
    tbl[2]  = mk(0, 0, 8'hFF, 32'h200, 64'h2000, 0, 4'hF, 32'h100, 1, 0);
    tbl[3]  = mk(0, 0, 8'hFF, 32'h300, 64'h3000, 0, 4'hF, 32'h100, 1, 0);
    tbl[4]  = mk(0, 0, 8'h00, 32'h000, 64'h0,    4, 4'hF, 32'h104, 1, 0);
    tbl[5]  = mk(0, 0, 8'h00, 32'h000, 64'h0,    4, 4'hF, 32'h200, 0, 0);
    tbl[6]  = mk(0, 0, 8'h00, 32'h000, 64'h0,    4, 4'hF, 32'h204, 0, 0);
    tbl[7]  = mk(0, 0, 8'h3F, 32'h400, 64'h4000, 4, 4'hF, 32'h400, 0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 32'h000, 64'h0,    4, 4'h3, 32'h404, 0, 0);
    tbl[9]  = mk(0, 0, 8'h00, 32'h000, 64'h0,    4, 4'h0, 32'h000, 0, 1);
    tbl[10] = mk(0, 0, 8'h0F, 32'h500, 64'h5000, 0, 4'hF, 32'h500, 0, 0);
    tbl[11] = mk(0, 0, 8'h3F, 32'h600, 64'h6000, 0, 4'hF, 32'h500, 1, 0);
    tbl[12] = mk(0, 1, 8'hFF, 32'h680, 64'h6800, 3, 4'h0, 32'h000, 0, 1);
    tbl[13] = mk(0, 0, 8'hB7, 32'h700, 64'h7000, 0, 4'h7, 32'h700, 0, 0);
    tbl[14] = mk(0, 0, 8'hFF, 32'h800, 64'h8000, 0, 4'hF, 32'h700, 1, 0);
    tbl[15] = mk(1, 0, 8'hFF, 32'h900, 64'h9000, 0, 4'h0, 32'h000, 0, 1);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].rst, tbl[i].flush, tbl[i].vld, seq_insts(tbl[i].ib), tbl[i].pc, tbl[i].deq);
      chk($sformatf("t%0d_vld", i),   {252'd0, out_vld_o},        {252'd0, tbl[i].evld});
      chk($sformatf("t%0d_inst0", i), {224'd0, out_inst_o[31:0]}, {224'd0, tbl[i].einst0});
      chk($sformatf("t%0d_full", i),  {255'd0, full_o},           {255'd0, tbl[i].efull});
      chk($sformatf("t%0d_empty", i), {255'd0, empty_o},          {255'd0, tbl[i].eempty});
      model_check();
    end

    // Streaming sequence: steady push 8 / pop 4 until backpressure, then drain.
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 8'hFF, seq_insts(32'hA00 + 32'(16 * i)), 64'hA000 + 64'(64 * i), 4);
      model_check();
    end
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 8'h00, '0, 64'h0, 4);
      model_check();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 8; k++) ri[32*k +: 32] = $urandom;
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        len = $urandom_range(0, 8);
        rv  = 8'((16'h1 << len) - 16'h1);
      end else begin
        rv = 8'($urandom);
      end
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, rv, ri, rp,
            3'($urandom_range(0, 4)));
      model_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
